// File: rtl/wm_insert_ctrl.sv
// Watermark insertion sequencer: fetches a 2x2 edge-replicated neighbourhood plus one
// watermark symbol per pixel, presents them to an external datapath and writes the result.
module wm_insert_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    a1_cfg,
    input  logic [7:0]    a2_cfg,
    output logic          busy,
    output logic          done,
    output logic          img_rd_en,
    output logic [AW-1:0] img_addr,
    input  logic [7:0]    img_rd_data,
    output logic          wm_rd_en,
    output logic [AW-1:0] wm_addr,
    input  logic [1:0]    wm_rd_data,
    output logic [7:0]    dp_data1,
    output logic [7:0]    dp_data2,
    output logic [7:0]    dp_data3,
    output logic [7:0]    dp_data4,
    output logic [7:0]    dp_a1,
    output logic [7:0]    dp_a2,
    output logic [1:0]    dp_wm_data,
    input  logic [7:0]    dp_result,
    output logic          out_wr_en,
    output logic [AW-1:0] out_addr,
    output logic [7:0]    out_wr_data
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        F0   = 3'd1,
        F1   = 3'd2,
        F2   = 3'd3,
        F3   = 3'd4,
        CAP  = 3'd5,
        WR   = 3'd6,
        FIN  = 3'd7
    } state_t;

    localparam logic [AW-1:0] W_LAST   = AW'(IMG_W - 1);
    localparam logic [AW-1:0] H_LAST   = AW'(IMG_H - 1);
    localparam logic [AW-1:0] P_LAST   = AW'(IMG_W * IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

    state_t        state_q, state_d;
    logic [AW-1:0] r_q, r_d;
    logic [AW-1:0] c_q, c_d;
    logic [AW-1:0] p_q, p_d;
    logic [7:0]    a1_q, a1_d;
    logic [7:0]    a2_q, a2_d;
    logic [7:0]    d1_q, d1_d;
    logic [7:0]    d2_q, d2_d;
    logic [7:0]    d3_q, d3_d;
    logic [7:0]    d4_q, d4_d;
    logic [1:0]    wm_q, wm_d;
    logic [AW-1:0] img_addr_q, img_addr_d;
    logic [AW-1:0] wm_addr_q, wm_addr_d;
    logic [AW-1:0] out_addr_q, out_addr_d;

    // Neighbour offsets collapse to zero on the right/bottom edge (edge replication).
    logic [AW-1:0] col_step;
    logic [AW-1:0] row_step;

    assign col_step = (c_q != W_LAST) ? AW'(1) : '0;
    assign row_step = (r_q != H_LAST) ? ROW_STEP : '0;

    assign img_addr   = img_addr_d;
    assign wm_addr    = wm_addr_d;
    assign out_addr   = out_addr_d;
    assign dp_data1   = d1_q;
    assign dp_data2   = d2_q;
    assign dp_data3   = d3_q;
    assign dp_data4   = d4_q;
    assign dp_a1      = a1_q;
    assign dp_a2      = a2_q;
    assign dp_wm_data = wm_q;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        p_d         = p_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        d4_d        = d4_q;
        wm_d        = wm_q;
        img_addr_d  = img_addr_q;
        wm_addr_d   = wm_addr_q;
        out_addr_d  = out_addr_q;
        busy        = 1'b0;
        done        = 1'b0;
        img_rd_en   = 1'b0;
        wm_rd_en    = 1'b0;
        out_wr_en   = 1'b0;
        out_wr_data = 8'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a1_d    = a1_cfg;
                    a2_d    = a2_cfg;
                    r_d     = '0;
                    c_d     = '0;
                    p_d     = '0;
                    state_d = F0;
                end
            end
            F0: begin
                busy       = 1'b1;
                img_rd_en  = 1'b1;
                img_addr_d = p_q;
                wm_rd_en   = 1'b1;
                wm_addr_d  = p_q;
                state_d    = F1;
            end
            // Each fetch state captures the word requested one cycle earlier.
            F1: begin
                busy       = 1'b1;
                d1_d       = img_rd_data;
                wm_d       = wm_rd_data;
                img_rd_en  = 1'b1;
                img_addr_d = p_q + col_step;
                state_d    = F2;
            end
            F2: begin
                busy       = 1'b1;
                d2_d       = img_rd_data;
                img_rd_en  = 1'b1;
                img_addr_d = p_q + row_step;
                state_d    = F3;
            end
            F3: begin
                busy       = 1'b1;
                d3_d       = img_rd_data;
                img_rd_en  = 1'b1;
                img_addr_d = p_q + row_step + col_step;
                state_d    = CAP;
            end
            CAP: begin
                busy    = 1'b1;
                d4_d    = img_rd_data;
                state_d = WR;
            end
            WR: begin
                busy        = 1'b1;
                out_wr_en   = 1'b1;
                out_addr_d  = p_q;
                out_wr_data = dp_result;
                if (p_q == P_LAST) begin
                    state_d = FIN;
                end else begin
                    p_d     = p_q + AW'(1);
                    state_d = F0;
                    if (c_q == W_LAST) begin
                        c_d = '0;
                        r_d = r_q + AW'(1);
                    end else begin
                        c_d = c_q + AW'(1);
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            a1_q       <= 8'd0;
            a2_q       <= 8'd0;
            d1_q       <= 8'd0;
            d2_q       <= 8'd0;
            d3_q       <= 8'd0;
            d4_q       <= 8'd0;
            wm_q       <= 2'd0;
            img_addr_q <= '0;
            wm_addr_q  <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            p_q        <= p_d;
            a1_q       <= a1_d;
            a2_q       <= a2_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            d3_q       <= d3_d;
            d4_q       <= d4_d;
            wm_q       <= wm_d;
            img_addr_q <= img_addr_d;
            wm_addr_q  <= wm_addr_d;
            out_addr_q <= out_addr_d;
        end
    end

endmodule

// File: tb/tb_wm_insert_ctrl.sv
// Bench for wm_insert_ctrl on a 4x4 image: RAM models, a datapath model and a
// scoreboard of expected read addresses and output writes.
module tb_wm_insert_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    a1_cfg = 8'd0;
    logic [7:0]    a2_cfg = 8'd0;
    logic          busy, done;
    logic          img_rd_en, wm_rd_en, out_wr_en;
    logic [AW-1:0] img_addr, wm_addr, out_addr;
    logic [7:0]    img_rd_data = 8'd0;
    logic [1:0]    wm_rd_data = 2'd0;
    logic [7:0]    dp_data1, dp_data2, dp_data3, dp_data4, dp_a1, dp_a2;
    logic [1:0]    dp_wm_data;
    logic [7:0]    dp_result;
    logic [7:0]    out_wr_data;

    logic          dp_mode = 1'b0;
    logic [7:0]    img_mem [N];
    logic [1:0]    wm_mem  [N];

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [7:0]    a1;
        logic [7:0]    a2;
        logic [1:0]    wm;
    } wr_t;

    wr_t           exp_wr [$];
    logic [AW-1:0] exp_rd [$];
    logic [AW-1:0] rd_log [N][4];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int f0_cyc   = 0;
    int done_cyc = 0;
    int cur_p    = 0;
    int rk       = 0;

    wm_insert_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a1_cfg(a1_cfg), .a2_cfg(a2_cfg),
        .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
        .wm_rd_en(wm_rd_en), .wm_addr(wm_addr), .wm_rd_data(wm_rd_data),
        .dp_data1(dp_data1), .dp_data2(dp_data2), .dp_data3(dp_data3), .dp_data4(dp_data4),
        .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_wm_data(dp_wm_data), .dp_result(dp_result),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .out_wr_data(out_wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (img_rd_en) img_rd_data <= img_mem[img_addr];
        if (wm_rd_en)  wm_rd_data  <= wm_mem[wm_addr];
    end

    function automatic logic [7:0] dp_f(input logic [7:0] d1, input logic [7:0] d2,
                                        input logic [7:0] d3, input logic [7:0] d4,
                                        input logic [1:0] wm, input logic [7:0] a1,
                                        input logic [7:0] a2);
        int s;
        s = int'(d1) + 2 * int'(d2) + 3 * int'(d3) + 5 * int'(d4) + 7 * int'(wm) + int'(a1 ^ a2);
        return s[7:0];
    endfunction

    assign dp_result = dp_mode ? dp_f(dp_data1, dp_data2, dp_data3, dp_data4, dp_wm_data, dp_a1, dp_a2)
                               : dp_data1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_ctrl"}, {busy, done, img_rd_en, wm_rd_en, out_wr_en,
                               img_addr, wm_addr, out_addr, out_wr_data}, 64'd0);
        check({tag, "_dp"}, {dp_data1, dp_data2, dp_data3, dp_data4, dp_a1, dp_a2, dp_wm_data}, 64'd0);
    endtask

    // Expected reads and writes of one frame, from the current memory contents.
    task automatic push_frame(input logic [7:0] a1, input logic [7:0] a2);
        for (int p = 0; p < N; p++) begin
            int  r, c, rn, cn, i1, i2, i3, i4;
            wr_t e;
            r  = p / W;
            c  = p % W;
            cn = (c < W - 1) ? c + 1 : c;
            rn = (r < H - 1) ? r + 1 : r;
            i1 = r * W + c;
            i2 = r * W + cn;
            i3 = rn * W + c;
            i4 = rn * W + cn;
            exp_rd.push_back(AW'(i1));
            exp_rd.push_back(AW'(i2));
            exp_rd.push_back(AW'(i3));
            exp_rd.push_back(AW'(i4));
            e.addr = AW'(p);
            e.wm   = wm_mem[p];
            e.a1   = a1;
            e.a2   = a2;
            e.data = dp_mode ? dp_f(img_mem[i1], img_mem[i2], img_mem[i3], img_mem[i4], wm_mem[p], a1, a2)
                             : img_mem[i1];
            exp_wr.push_back(e);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int i;
        i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (wm_rd_en) begin
            cur_p = int'(wm_addr);
            rk    = 0;
            if (wm_addr == '0) f0_cyc = cyc;
        end
        if (img_rd_en) begin
            if (rk < 4) rd_log[cur_p][rk] = img_addr;
            rk++;
            if (exp_rd.size() == 0) check("rd_unexpected", 64'(img_addr), 64'hFFFF);
            else check("rd_addr", 64'(img_addr), 64'(exp_rd.pop_front()));
        end
        if (out_wr_en) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 64'(out_addr), 64'hFFFF);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 64'(out_addr), 64'(e.addr));
                check("wr_data", 64'(out_wr_data), 64'(e.data));
                check("wr_dp_a1", 64'(dp_a1), 64'(e.a1));
                check("wr_dp_a2", 64'(dp_a2), 64'(e.a2));
                check("wr_dp_wm", 64'(dp_wm_data), 64'(e.wm));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", 64'(busy), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, db, saved, i;
        logic [7:0] ra1, ra2;

        for (int p = 0; p < N; p++) begin
            img_mem[p] = 8'(p + 1);
            wm_mem[p]  = 2'b00;
        end

        #12;
        zero_check("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        zero_check("idle_after_reset");

        // Frame 1: identity datapath, strengths 3/5, then cfg changes and a stray start while busy.
        dp_mode = 1'b0;
        a1_cfg  = 8'd3;
        a2_cfg  = 8'd5;
        push_frame(8'd3, 8'd5);
        wb = wr_cnt;
        db = done_cnt;
        pulse_start();
        a1_cfg = 8'd9;
        a2_cfg = 8'd9;
        repeat (18) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(db + 1, 300, "f1_done_seen");
        check("f1_latency", 64'(done_cyc - f0_cyc), 64'd96);
        repeat (8) @(negedge clk);
        check("f1_writes", 64'(wr_cnt - wb), 64'd16);
        check("f1_dones", 64'(done_cnt - db), 64'd1);
        check("f1_idle_busy", 64'(busy), 64'd0);
        check("f1_wr_left", 64'(exp_wr.size()), 64'd0);
        check("corner_p15", {rd_log[15][0], rd_log[15][1], rd_log[15][2], rd_log[15][3]}, 64'hFFFF);
        check("edge_p3", {rd_log[3][0], rd_log[3][1], rd_log[3][2], rd_log[3][3]}, 64'h3377);
        check("edge_p12", {rd_log[12][0], rd_log[12][1], rd_log[12][2], rd_log[12][3]}, 64'hCDCD);

        // Frame 2: random image, watermark and strengths through a mixing datapath.
        dp_mode = 1'b1;
        for (int p = 0; p < N; p++) begin
            img_mem[p] = 8'($urandom_range(0, 255));
            wm_mem[p]  = 2'($urandom_range(0, 3));
        end
        ra1 = 8'($urandom_range(0, 255));
        ra2 = 8'($urandom_range(0, 255));
        a1_cfg = ra1;
        a2_cfg = ra2;
        push_frame(ra1, ra2);
        wb = wr_cnt;
        db = done_cnt;
        pulse_start();
        a1_cfg = ~ra1;
        wait_done(db + 1, 300, "f2_done_seen");
        check("f2_latency", 64'(done_cyc - f0_cyc), 64'd96);
        check("f2_writes", 64'(wr_cnt - wb), 64'd16);

        // Frame 3: reset during F2 of pixel 5 aborts the frame.
        push_frame(ra1, ra2);
        a1_cfg = ra1;
        wb = wr_cnt;
        db = done_cnt;
        pulse_start();
        i = 0;
        while (!(wm_rd_en && wm_addr == AW'(5)) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("abort_reach_p5", 64'(wm_rd_en && wm_addr == AW'(5)), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        zero_check("abort_reset");
        exp_wr.delete();
        exp_rd.delete();
        repeat (6) @(negedge clk);
        check("abort_writes", 64'(wr_cnt - wb), 64'd5);
        check("abort_no_done", 64'(done_cnt - db), 64'd0);
        rst_n = 1'b1;
        push_frame(ra1, ra2);
        wb = wr_cnt;
        db = done_cnt;
        pulse_start();
        wait_done(db + 1, 300, "f3_done_seen");
        check("f3_writes", 64'(wr_cnt - wb), 64'd16);

        // Frames 4/5: start held high -> second frame begins right after the IDLE cycle.
        dp_mode = 1'b0;
        a1_cfg  = 8'd7;
        a2_cfg  = 8'd11;
        push_frame(8'd7, 8'd11);
        push_frame(8'd7, 8'd11);
        wb = wr_cnt;
        db = done_cnt;
        @(negedge clk);
        start = 1'b1;
        wait_done(db + 1, 300, "b2b_first_done");
        saved = done_cyc;
        i = 0;
        while (f0_cyc <= saved && i < 20) begin
            @(negedge clk);
            i++;
        end
        start = 1'b0;
        check("b2b_gap", 64'(f0_cyc - saved), 64'd2);
        wait_done(db + 2, 300, "b2b_second_done");
        repeat (10) @(negedge clk);
        check("b2b_dones", 64'(done_cnt - db), 64'd2);
        check("b2b_writes", 64'(wr_cnt - wb), 64'd32);
        check("b2b_rd_left", 64'(exp_rd.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wm_insert_ctrl.md
WM_INSERT_CTRL -- requirements
Module: wm_insert_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 8, meaning image width in pixels (>=2).
REQ-002 The block SHALL have parameter IMG_H, default 8, meaning image height in pixels (>=2).
REQ-003 The block SHALL have parameter AW, default 6, meaning address width, with 2^AW >= IMG_W*IMG_H.
REQ-004 Ports SHALL be exactly as follows (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a frame
- a1_cfg, a2_cfg  in  8 each  embedding strengths, latched at accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at frame completion
- img_rd_en  out  1  image RAM read strobe
- img_addr  out  AW  image RAM address
- img_rd_data  in  8  image RAM data, valid 1 cycle after img_rd_en
- wm_rd_en  out  1  watermark RAM read strobe
- wm_addr  out  AW  watermark RAM address
- wm_rd_data  in  2  watermark symbol, valid 1 cycle after wm_rd_en
- dp_data1..dp_data4  out  8 each  neighbourhood pixels to the insertion datapath
- dp_a1, dp_a2  out  8 each  latched strengths to the datapath
- dp_wm_data  out  2  watermark symbol to the datapath
- dp_result  in  8  combinational datapath result
- out_wr_en  out  1  output RAM write strobe
- out_addr  out  AW  output RAM address
- out_wr_data  out  8  output pixel

Function
REQ-005 Pixel index SHALL be p = r*IMG_W + c; the scan SHALL be raster order, c fastest, r=0..IMG_H-1, c=0..IMG_W-1.
REQ-006 Neighbourhood SHALL be D1=(r,c), D2=(r,c+1), D3=(r+1,c), D4=(r+1,c+1), with c+1 clamped to IMG_W-1 and r+1 clamped to IMG_H-1 (edge replication).
REQ-007 The FSM SHALL have states IDLE, F0, F1, F2, F3, CAP, WR, FIN.
REQ-008 In IDLE, start=1 SHALL latch a1_cfg/a2_cfg, clear r and c, set busy, and go to F0; start in any other state SHALL be ignored.
REQ-009 F0..F3 SHALL each assert img_rd_en for exactly one cycle, with img_addr set to the D1..D4 address respectively; F0 SHALL also assert wm_rd_en with wm_addr=p.
REQ-010 img_rd_data SHALL be captured into the D1 register in F1, D2 in F2, D3 in F3 and D4 in CAP; wm_rd_data SHALL be captured in F1.
REQ-011 dp_data1..4, dp_wm_data, dp_a1 and dp_a2 SHALL be driven from registers and SHALL be stable throughout WR.
REQ-012 WR SHALL assert out_wr_en for one cycle with out_addr=p and out_wr_data=dp_result.
REQ-013 After WR, if p = IMG_W*IMG_H-1 the FSM SHALL go to FIN; otherwise c SHALL increment, wrapping to 0 with r+1 when c = IMG_W-1, and the FSM SHALL go to F0.
REQ-014 Each pixel SHALL take exactly 6 cycles (F0..WR), so a frame takes 6*IMG_W*IMG_H cycles from the first F0.
REQ-015 FIN SHALL pulse done for one cycle, deassert busy in that same cycle, and return to IDLE.
REQ-016 A start arriving in the FIN cycle SHALL be ignored; a start arriving in the following IDLE cycle SHALL be accepted.
REQ-017 All strobes SHALL be 0 outside the states named above; addresses SHALL hold their last value when the associated strobe is 0.

Reset
REQ-018 While rst_n=0, the FSM SHALL be IDLE and every output and internal register SHALL be 0, asynchronously.
REQ-019 Reset asserted mid-frame SHALL abort the frame without a done pulse and without any further write; no resume is supported.
REQ-020 After rst_n rises, the first accepted start SHALL be the first start sampled on a rising edge at which rst_n=1.

Verification
REQ-021 4x4 image with pixel value p+1, watermark all 2'b00, identity datapath (result=D1) -> 16 writes, out[p]=p+1, done exactly 96 cycles after F0.
REQ-022 Pixel p=15 (corner) -> img_addr sequence 15,15,15,15; pixel p=3 -> 3,3,7,7; pixel p=12 -> 12,13,12,13.
REQ-023 start asserted while busy at cycle 20 -> no restart, write count stays 16, and a1/a2 remain at the values latched at the original start.
REQ-024 rst_n dropped during F2 of pixel 5 -> all outputs read 0 immediately, no further out_wr_en, no done; a new start then runs a full frame.
REQ-025 a1_cfg=3 and a2_cfg=5 at start, changed to 9 during the frame -> dp_a1=3 and dp_a2=5 for every pixel.
REQ-026 Back-to-back frames with start held high -> second frame begins in the IDLE cycle after FIN, with exactly one done pulse per frame.
